wb_trace_buffer: RTL and testbench

Writeback trace buffer for the MIPS pipeline. It captures every register-file write the pipeline retires and tags it with a cycle timestamp. Entries are held in a FIFO and drained by a consumer over a valid/ready handshake. This gives the bench side a retirement log that can be checked against a golden model instead of only watching the clock.

---
 rtl/wb_trace_buffer.sv | 144 ++++++++++++++
 tb/tb_wb_trace_buffer.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/wb_trace_buffer.sv
// Writeback trace buffer: stamps every retired register-file write and queues it in a
// show-ahead FIFO drained over valid/ready. Optional WB_TRACE_SKIP_R0_EN filters $zero writes.
module wb_trace_buffer #(
    parameter int unsigned DEPTH   = 16,
    parameter int unsigned STAMP_W = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wb_en,
    input  logic [4:0]               wb_reg,
    input  logic [31:0]              wb_data,
    input  logic                     clr,
    output logic                     rd_valid,
    input  logic                     rd_ready,
    output logic [STAMP_W-1:0]       rd_stamp,
    output logic [4:0]               rd_reg,
    output logic [31:0]              rd_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic [7:0]               drop_cnt
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    logic [STAMP_W-1:0] stamp_q;

    logic [STAMP_W-1:0] stamp_mem [DEPTH];
    logic [4:0]         reg_mem   [DEPTH];
    logic [31:0]        data_mem  [DEPTH];

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          overflow_q, overflow_d;
    logic [7:0]    drop_cnt_q, drop_cnt_d;

    logic push_req;
    logic empty;
    logic full;
    logic do_pop;
    logic do_push;
    logic do_drop;

`ifdef WB_TRACE_SKIP_R0_EN
    assign push_req = wb_en && (wb_reg != 5'd0);
`else
    assign push_req = wb_en;
`endif

    // Free-running cycle stamp; deliberately untouched by clr.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stamp_q <= '0;
        end else begin
            stamp_q <= stamp_q + STAMP_W'(1);
        end
    end

    assign empty = (count_q == '0);
    assign full  = (count_q == FULL_COUNT);

    // A pop at full frees the slot the simultaneous push needs, so nothing is dropped.
    always_comb begin
        do_pop  = !clr && !empty && rd_ready;
        do_push = !clr && push_req && (!full || do_pop);
        do_drop = !clr && push_req && full && !do_pop;
    end

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        drop_cnt_d = drop_cnt_q;
        if (clr) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            overflow_d = 1'b0;
            drop_cnt_d = '0;
        end else begin
            if (do_push) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            unique case ({do_push, do_pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
            if (do_drop) begin
                overflow_d = 1'b1;
                if (drop_cnt_q != 8'hff) begin
                    drop_cnt_d = drop_cnt_q + 8'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    // Storage is intentionally not reset; the read mux hides stale contents while empty.
    always_ff @(posedge clk) begin
        if (do_push) begin
            stamp_mem[wr_ptr_q] <= stamp_q;
            reg_mem[wr_ptr_q]   <= wb_reg;
            data_mem[wr_ptr_q]  <= wb_data;
        end
    end

    always_comb begin
        rd_valid = !empty;
        count    = count_q;
        overflow = overflow_q;
        drop_cnt = drop_cnt_q;
        rd_stamp = '0;
        rd_reg   = '0;
        rd_data  = '0;
        if (!empty) begin
            rd_stamp = stamp_mem[rd_ptr_q];
            rd_reg   = reg_mem[rd_ptr_q];
            rd_data  = data_mem[rd_ptr_q];
        end
    end

endmodule

// File: tb/tb_wb_trace_buffer.sv
// Self-checking bench for wb_trace_buffer: a scoreboard queue of expected entries plus a
// small occupancy/status model, checked on every falling edge.
module tb_wb_trace_buffer;

    localparam int unsigned DEPTH   = 16;
    localparam int unsigned STAMP_W = 16;

    logic                 clk;
    logic                 rst_n;
    logic                 wb_en;
    logic [4:0]           wb_reg;
    logic [31:0]          wb_data;
    logic                 clr;
    logic                 rd_valid;
    logic                 rd_ready;
    logic [STAMP_W-1:0]   rd_stamp;
    logic [4:0]           rd_reg;
    logic [31:0]          rd_data;
    logic [4:0]           count;
    logic                 overflow;
    logic [7:0]           drop_cnt;

    wb_trace_buffer #(
        .DEPTH   (DEPTH),
        .STAMP_W (STAMP_W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .wb_en    (wb_en),
        .wb_reg   (wb_reg),
        .wb_data  (wb_data),
        .clr      (clr),
        .rd_valid (rd_valid),
        .rd_ready (rd_ready),
        .rd_stamp (rd_stamp),
        .rd_reg   (rd_reg),
        .rd_data  (rd_data),
        .count    (count),
        .overflow (overflow),
        .drop_cnt (drop_cnt)
    );

    typedef struct packed {
        logic [STAMP_W-1:0] stamp;
        logic [4:0]         rnum;
        logic [31:0]        data;
    } ent_t;

    ent_t sb[$];
    logic [STAMP_W-1:0] m_stamp;
    logic               m_ovf;
    int                 m_drop;
    int                 n_checks;
    int                 n_pass;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference cycle counter: value seen on a falling edge is the stamp the next edge captures.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m_stamp <= '0;
        else        m_stamp <= m_stamp + 16'd1;
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    // Called on a falling edge: drive inputs, check current outputs, advance model, wait an edge.
    task automatic cycle(input logic en, input logic [4:0] r, input logic [31:0] d,
                         input logic rdy, input logic c);
        logic req;
        logic pop;
        logic full;
        ent_t e;
        wb_en    = en;
        wb_reg   = r;
        wb_data  = d;
        rd_ready = rdy;
        clr      = c;
        check_eq("rd_valid", 64'(rd_valid), 64'(sb.size() != 0));
        check_eq("count", 64'(count), 64'(sb.size()));
        check_eq("overflow", 64'(overflow), 64'(m_ovf));
        check_eq("drop_cnt", 64'(drop_cnt), 64'(m_drop));
        if (sb.size() != 0) begin
            check_eq("rd_stamp", 64'(rd_stamp), 64'(sb[0].stamp));
            check_eq("rd_reg", 64'(rd_reg), 64'(sb[0].rnum));
            check_eq("rd_data", 64'(rd_data), 64'(sb[0].data));
        end else begin
            check_eq("empty_out", {rd_stamp, rd_reg, rd_data}, 64'd0);
        end
`ifdef WB_TRACE_SKIP_R0_EN
        req = en && (r != 5'd0);
`else
        req = en;
`endif
        if (c) begin
            sb.delete();
            m_ovf  = 1'b0;
            m_drop = 0;
        end else begin
            full = (sb.size() == DEPTH);
            pop  = (sb.size() != 0) && rdy;
            if (pop) void'(sb.pop_front());
            if (req && (!full || pop)) begin
                e.stamp = m_stamp;
                e.rnum  = r;
                e.data  = d;
                sb.push_back(e);
            end else if (req) begin
                m_ovf = 1'b1;
                if (m_drop < 255) m_drop++;
            end
        end
        @(negedge clk);
    endtask

    task automatic idle(input logic rdy);
        cycle(1'b0, 5'd0, 32'd0, rdy, 1'b0);
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        m_ovf    = 1'b0;
        m_drop   = 0;
        rst_n    = 1'b0;
        wb_en    = 1'b0;
        wb_reg   = '0;
        wb_data  = '0;
        rd_ready = 1'b0;
        clr      = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Basic push/pop with known stamps 3 and 4.
        repeat (3) idle(1'b0);
        cycle(1'b1, 5'd8, 32'h0000_0005, 1'b0, 1'b0);
        cycle(1'b1, 5'd9, 32'hDEAD_BEEF, 1'b0, 1'b0);
        check_eq("t1_count", 64'(count), 64'd2);
        check_eq("t1_head_stamp", 64'(rd_stamp), 64'd3);
        check_eq("t1_head_reg", 64'(rd_reg), 64'd8);
        idle(1'b1);
        check_eq("t1_second_stamp", 64'(rd_stamp), 64'd4);
        idle(1'b1);
        check_eq("t1_drained", 64'({rd_valid, count}), 64'd0);
        idle(1'b0);

        // Overflow: 20 pushes into 16 slots.
        for (int i = 0; i < 20; i++) begin
            cycle(1'b1, 5'(i + 1), 32'hA000_0000 + 32'(i), 1'b0, 1'b0);
        end
        check_eq("ovf_count", 64'(count), 64'd16);
        check_eq("ovf_flag", 64'(overflow), 64'd1);
        check_eq("ovf_drops", 64'(drop_cnt), 64'd4);
        check_eq("ovf_head_reg", 64'(rd_reg), 64'd1);

        // Push and pop together at full: no drop, new event lands at the tail.
        cycle(1'b1, 5'd30, 32'hCAFE_0000, 1'b1, 1'b0);
        check_eq("fullpp_count", 64'(count), 64'd16);
        check_eq("fullpp_drops", 64'(drop_cnt), 64'd4);
        repeat (17) idle(1'b1);

        // $zero write.
        cycle(1'b1, 5'd0, 32'h0000_1234, 1'b0, 1'b0);
`ifdef WB_TRACE_SKIP_R0_EN
        check_eq("r0_count", 64'(count), 64'd0);
`else
        check_eq("r0_count", 64'(count), 64'd1);
        check_eq("r0_reg", 64'(rd_reg), 64'd0);
`endif
        repeat (2) idle(1'b1);

        // Overflow again, then clr with a concurrent push.
        for (int i = 0; i < 18; i++) begin
            cycle(1'b1, 5'd12, 32'hB000_0000 + 32'(i), 1'b0, 1'b0);
        end
        cycle(1'b1, 5'd7, 32'h7777_7777, 1'b1, 1'b1);
        check_eq("clr_state", 64'({rd_valid, overflow, count, drop_cnt}), 64'd0);
        idle(1'b0);

        // Stamp wrap after a long idle stretch, with rd_ready held high.
        wb_en    = 1'b0;
        rd_ready = 1'b1;
        repeat (70000) @(negedge clk);
        cycle(1'b1, 5'd3, 32'h0BAD_F00D, 1'b1, 1'b0);
        cycle(1'b1, 5'd4, 32'h1111_2222, 1'b1, 1'b1 ^ 1'b1);
        repeat (2) idle(1'b1);

        // Asynchronous reset mid-stream.
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 5'd20, 32'hC000_0000 + 32'(i), 1'b0, 1'b0);
        end
        #2 rst_n = 1'b0;
        #1;
        check_eq("arst_count", 64'(count), 64'd0);
        check_eq("arst_valid", 64'(rd_valid), 64'd0);
        sb.delete();
        m_ovf  = 1'b0;
        m_drop = 0;
        @(negedge clk);
        rst_n = 1'b1;
        idle(1'b0);
        cycle(1'b1, 5'd21, 32'h5555_AAAA, 1'b1, 1'b0);
        repeat (2) idle(1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
